if_stage: RTL

- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage pipelined RV32I core.
- Owns the PC and drives the instruction-memory address.
- Captures {PC, instruction, PC+4, valid} into IF/ID, which directly feeds the ID-stage decoder.
- Honours stall requests from the hazard unit and redirects (taken branch / JAL / JALR) from EX.

---
 rtl/core_pkg.sv | 38 +++
 rtl/if_stage_if.sv | 24 ++
 rtl/if_stage_id_reg.sv | 27 ++
 rtl/if_stage.sv | 54 +++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions for the 5-stage RV32I pipeline.
// Holds fetch constants, decoder encodings and the IF/ID payload type.
package core_pkg;

    localparam int          XLEN             = 32;
    localparam logic [31:0] PC_INC           = 32'd4;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // ADDI x0,x0,0
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_OP_IMM = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU, WB_MEM, WB_PC4
    } wb_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] instr;
        logic            vld;
    } if_id_t;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, instruction-memory port, IF/ID outputs.
interface if_stage_if;

    logic                       i_stall;
    logic                       i_redirect;
    logic [core_pkg::XLEN-1:0]  i_redirect_pc;
    logic [core_pkg::XLEN-1:0]  o_imem_addr;
    logic [core_pkg::XLEN-1:0]  i_imem_rdata;
    logic [core_pkg::XLEN-1:0]  o_id_pc;
    logic [core_pkg::XLEN-1:0]  o_id_pc4;
    logic [core_pkg::XLEN-1:0]  o_id_instr;
    logic                       o_id_vld;

    modport master (
        input  i_stall, i_redirect, i_redirect_pc, i_imem_rdata,
        output o_imem_addr, o_id_pc, o_id_pc4, o_id_instr, o_id_vld
    );

    modport slave (
        output i_stall, i_redirect, i_redirect_pc, i_imem_rdata,
        input  o_imem_addr, o_id_pc, o_id_pc4, o_id_instr, o_id_vld
    );

endinterface

// File: rtl/if_stage_id_reg.sv
// IF/ID pipeline register: flush beats load; neither means hold.
// A flush keeps pc/pc4 so only the instruction slot turns into a bubble.
module if_id_reg #(
    parameter logic [31:0] BUBBLE_INSTR = core_pkg::NOP_INSTR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             flush,
    input  logic [31:0]      pc,
    input  logic [31:0]      instr,
    output core_pkg::if_id_t q
);
    import core_pkg::*;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '{pc: '0, pc4: PC_INC, instr: BUBBLE_INSTR, vld: 1'b0};
        end else if (flush) begin
            q.instr <= BUBBLE_INSTR;
            q.vld   <= 1'b0;
        end else if (load) begin
            q <= '{pc: pc, pc4: pc + PC_INC, instr: instr, vld: 1'b1};
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, drives imem, and fills IF/ID.
// Edge priority: reset > redirect > stall > advance.
module if_stage #(
    parameter logic [31:0] RESET_PC  = core_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic       i_clk,
    input  logic       i_reset,
    if_stage_if.master bus
);
    import core_pkg::*;

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic            advance;
    if_id_t          id_q;

    assign advance = !bus.i_redirect && !bus.i_stall;

    // Redirect targets are word-aligned by dropping the low bits.
    always_comb begin
        pc_d = pc_q;
        if (bus.i_redirect)
            pc_d = {bus.i_redirect_pc[XLEN-1:2], 2'b00};
        else if (!bus.i_stall)
            pc_d = pc_q + PC_INC;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset)
            pc_q <= RESET_PC;
        else
            pc_q <= pc_d;
    end

    if_id_reg #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk   (i_clk),
        .rst_n (i_reset),
        .load  (advance),
        .flush (bus.i_redirect),
        .pc    (pc_q),
        .instr (bus.i_imem_rdata),
        .q     (id_q)
    );

    assign bus.o_imem_addr = pc_q;
    assign bus.o_id_pc     = id_q.pc;
    assign bus.o_id_pc4    = id_q.pc4;
    assign bus.o_id_instr  = id_q.instr;
    assign bus.o_id_vld    = id_q.vld;

endmodule
